cla_adder_pipe: RTL and testbench
=================================

Name: cla_adder_pipe

Overview:
- Two-stage pipelined N-bit adder/subtractor built around the existing cla_unit carry-lookahead block.
- Upstream half registers operands and forms per-bit p = a^b_eff, g = a&b_eff feeding cla_unit.
- Downstream half consumes cla_unit carries, forms sum bits, registers result.
- Valid/ready handshake on both sides; full throughput (1 op/cycle) when unstalled.

Parameters:
- N, 16, operand/sum width; passed unchanged to cla_unit (N >= 2).

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts beat this cycle
- a  input  N  operand A
- b  input  N  operand B
- cin  input  1  carry-in (add mode only)
- sub  input  1  1 = subtract: result = a + ~b + 1, cin ignored
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  N  result bits
- cout  output  1  carry out of bit N-1 (= cla_unit cout)

Behaviour:
- Reset: clk and rst only; synchronous active-high. On rst: s0_valid=0, s1_valid=0, all data regs = 0; outputs out_valid=0, sum=0, cout=0, in_ready=1 from first cycle after reset. Reset mid-stream drops all in-flight ops, no output produced for them.
- Input accept: transfer when in_valid && in_ready at rising edge.
- Stage 0 (S0) captures a_r = a, b_r = sub ? ~b : b, ci_r = sub ? 1 : cin, s0_valid=1.
- Combinational between S0 and S1: p = a_r ^ b_r, g = a_r & b_r; cla_unit(.p,.g,.cin(ci_r)) gives c[N:1]; sum_next[0] = p[0]^ci_r, sum_next[k] = p[k]^c[k] for k=1..N-1; cout_next = c[N]. PG/GG of cla_unit unused.
- Stage 1 (S1) = output register: sum, cout, s1_valid (= out_valid).
- Advance rules: s1_adv = !s1_valid || out_ready; s0_adv = s0_valid && s1_adv; in_ready = !s0_valid || s1_adv.
- On s1_adv: s1_valid <= s0_valid; if s0_valid, sum/cout load sum_next/cout_next.
- On in_ready: s0_valid <= in_valid; data loads only if in_valid.
- Latency: result of beat accepted at edge T is out_valid at edge T+2 (no stall).
- Backpressure: out_ready=0 with both stages full -> in_ready=0; sum/cout/out_valid held stable until accepted; no beat lost or duplicated.
- Simultaneous accept and drain in same cycle allowed when full: S1 drains, S0 moves to S1, new beat into S0.
- in_ready must not combinationally depend on in_valid; depends on out_ready (no skid buffer).
- Arithmetic: modulo 2^N; cout in sub mode = 1 means no borrow (a >= b unsigned).
- Data regs update only on handshake/advance; idle values don't-care but held.

Optional Feature:
- Macro CLA_ADDER_OVF_EN.
- Defined: extra output port ovf (output, 1): signed two's-complement overflow = c[N] ^ c[N-1], registered in S1 alongside sum, reset 0, held under stall.
- Undefined: port ovf absent; no extra logic.

Test Plan:
- Reset then single add: a=16'h1234, b=16'h0FF0, cin=0, sub=0 -> 2 cycles later out_valid=1, sum=16'h2224, cout=0.
- Carry ripple full width: a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, cout=1; with CLA_ADDER_OVF_EN, ovf=0.
- Subtract: a=16'h0005, b=16'h0007, sub=1, cin=1 (ignored) -> sum=16'hFFFE, cout=0; a=16'h8000, b=16'h0001, sub=1 -> sum=16'h7FFF, cout=1, ovf=1.
- Backpressure: stream 4 beats back-to-back, hold out_ready=0 -> in_ready drops after 2 accepted, out_valid/sum stable; release -> all 4 results in order, one per cycle, no loss/duplication.
- Reset mid-operation: 2 beats in flight, assert rst one cycle -> out_valid=0, sum=0, cout=0, in_ready=1 next cycle; no stale result emerges.
- Random 1000 beats with random in_valid/out_ready toggling, compared against a+b+cin / a-b scoreboard (and ovf when enabled) -> zero mismatches.

Source files
------------

// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined N-bit adder/subtractor with valid/ready on both sides.
// Optional macro CLA_ADDER_OVF_EN adds a registered signed-overflow output (ovf).

// Carry-lookahead block in 4-bit groups. The last group is padded with propagate=1,
// generate=0, so its group carry equals the carry out of bit N-1.
// The word-level PG/GG are not needed by the pipeline, so they are not brought out.
module cla_unit #(
  parameter int N = 16
) (
  input  logic [N-1:0] p,
  input  logic [N-1:0] g,
  input  logic         cin,
  output logic [N:1]   c
);
  localparam int NG = (N + 3) / 4;
  localparam int W  = NG * 4;

  logic [W-1:0] p_x;
  logic [W-1:0] g_x;
  logic [NG:0]  gc;
  logic [W:1]   c_x;

  always_comb begin
    p_x        = '1;
    g_x        = '0;
    p_x[N-1:0] = p;
    g_x[N-1:0] = g;
  end

  assign gc[0] = cin;

  generate
    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
      logic [3:0] lp;
      logic [3:0] lg;
      logic       c0;
      logic       grp_p;
      logic       grp_g;

      assign lp = p_x[4*gi +: 4];
      assign lg = g_x[4*gi +: 4];
      assign c0 = gc[gi];

      assign c_x[4*gi+1] = lg[0] | (lp[0] & c0);
      assign c_x[4*gi+2] = lg[1] | (lp[1] & lg[0]) | (lp[1] & lp[0] & c0);
      assign c_x[4*gi+3] = lg[2] | (lp[2] & lg[1]) | (lp[2] & lp[1] & lg[0])
                         | (lp[2] & lp[1] & lp[0] & c0);
      assign c_x[4*gi+4] = grp_g | (grp_p & c0);

      assign grp_p = &lp;
      assign grp_g = lg[3] | (lp[3] & lg[2]) | (lp[3] & lp[2] & lg[1])
                   | (lp[3] & lp[2] & lp[1] & lg[0]);

      assign gc[gi+1] = grp_g | (grp_p & c0);
    end
  endgenerate

  assign c = c_x[N:1];
endmodule

module cla_adder_pipe #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout
`ifdef CLA_ADDER_OVF_EN
  ,
  output logic         ovf
`endif
);
  logic         s0_valid_q, s0_valid_d;
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;
  logic         ci_q, ci_d;
  logic         s1_valid_q, s1_valid_d;
  logic [N-1:0] sum_q, sum_d;
  logic         cout_q, cout_d;

  logic         s1_adv;
  logic [N-1:0] p_w;
  logic [N-1:0] g_w;
  logic [N:1]   c_w;
  logic [N-1:0] sum_nx;

  // in_ready looks only at pipeline state and out_ready, never at in_valid.
  assign s1_adv   = !s1_valid_q || out_ready;
  assign in_ready = !s0_valid_q || s1_adv;

  assign p_w = a_q ^ b_q;
  assign g_w = a_q & b_q;

  cla_unit #(.N(N)) u_cla (
    .p   (p_w),
    .g   (g_w),
    .cin (ci_q),
    .c   (c_w)
  );

  assign sum_nx = p_w ^ {c_w[N-1:1], ci_q};

  always_comb begin
    s0_valid_d = s0_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    ci_d       = ci_q;
    if (in_ready) begin
      s0_valid_d = in_valid;
      if (in_valid) begin
        a_d  = a;
        b_d  = sub ? ~b : b;
        ci_d = sub ? 1'b1 : cin;
      end
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    if (s1_adv) begin
      s1_valid_d = s0_valid_q;
      if (s0_valid_q) begin
        sum_d  = sum_nx;
        cout_d = c_w[N];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      ci_q       <= 1'b0;
      s1_valid_q <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
    end else begin
      s0_valid_q <= s0_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      ci_q       <= ci_d;
      s1_valid_q <= s1_valid_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
    end
  end

  assign out_valid = s1_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

`ifdef CLA_ADDER_OVF_EN
  // Signed overflow: carry into the sign bit differs from carry out of it.
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (s1_adv && s0_valid_q) begin
      ovf_d = c_w[N] ^ c_w[N-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif
endmodule

// File: tb/tb_cla_adder_pipe.sv
// Directed-vector and scoreboard bench for cla_adder_pipe (N=16).
// Define CLA_ADDER_OVF_EN for both RTL and bench to also check ovf.
module tb_cla_adder_pipe;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
`ifdef CLA_ADDER_OVF_EN
  logic         ovf;
`endif

  cla_adder_pipe #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef CLA_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference result packed as {ovf, cout, sum}.
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mcin, input logic msub);
    logic [15:0] bb;
    logic [16:0] r;
    logic        ci;
    logic        ov;
    bb = msub ? ~mb : mb;
    ci = msub ? 1'b1 : mcin;
    r  = {1'b0, ma} + {1'b0, bb} + {16'd0, ci};
    ov = (ma[15] == bb[15]) && (r[15] != ma[15]);
    return {ov, r[16], r[15:0]};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[12];
    logic [17:0] expq[$];
    logic [17:0] e;
    logic [15:0] bp_a[4];
    logic [15:0] bp_b[4];
    logic [17:0] bp_e[4];
    logic [15:0] held_sum;
    logic        held;
    int          lat, idx, nout, first_cyc, last_cyc, nacc, cyc;

    vt[0]  = '{16'h1234, 16'h0FF0, 1'b0, 1'b0, 16'h2224, 1'b0, 1'b0};
    vt[1]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[2]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vt[3]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vt[4]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[5]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vt[6]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vt[7]  = '{16'hAAAA, 16'h5555, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    vt[8]  = '{16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[9]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vt[10] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vt[11] = '{16'h0001, 16'h8000, 1'b0, 1'b1, 16'h8001, 1'b0, 1'b1};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sum", {16'd0, sum}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef CLA_ADDER_OVF_EN
    check("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    tick();

    // Directed table: one beat at a time into an empty pipe.
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; a = vt[i].a; b = vt[i].b; cin = vt[i].cin; sub = vt[i].sub;
      #1;
      check($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      check($sformatf("vec%0d_early_valid", i), {31'd0, out_valid}, 32'd0);
      lat = 0;
      while (!out_valid && lat < 8) begin
        tick();
        lat++;
      end
      check($sformatf("vec%0d_latency", i), lat, 1);
      check($sformatf("vec%0d_sum", i), {16'd0, sum}, {16'd0, vt[i].sum});
      check($sformatf("vec%0d_cout", i), {31'd0, cout}, {31'd0, vt[i].cout});
`ifdef CLA_ADDER_OVF_EN
      check($sformatf("vec%0d_ovf", i), {31'd0, ovf}, {31'd0, vt[i].ovf});
`endif
      tick();
      check($sformatf("vec%0d_drain", i), {31'd0, out_valid}, 32'd0);
    end

    // Backpressure: four beats offered while the consumer stalls.
    bp_a[0] = 16'h0101; bp_b[0] = 16'h0202;
    bp_a[1] = 16'hF000; bp_b[1] = 16'h1000;
    bp_a[2] = 16'h0003; bp_b[2] = 16'h0009;
    bp_a[3] = 16'h4444; bp_b[3] = 16'h1111;
    for (int k = 0; k < 4; k++) bp_e[k] = model(bp_a[k], bp_b[k], 1'b0, k == 2);
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (idx < 4);
      a = bp_a[idx % 4]; b = bp_b[idx % 4]; cin = 1'b0; sub = (idx == 2);
      #1;
      if (in_valid && in_ready) idx++;
      if (c >= 3) check("bp_hold_sum", {16'd0, sum}, {16'd0, bp_e[0][15:0]});
      tick();
    end
    #1;
    check("bp_accepted", idx, 2);
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    check("bp_cout", {31'd0, cout}, {31'd0, bp_e[0][16]});
    out_ready = 1'b1;
    nout = 0; first_cyc = -1; last_cyc = -1;
    for (int c = 0; c < 10; c++) begin
      in_valid = (idx < 4);
      a = bp_a[idx % 4]; b = bp_b[idx % 4]; cin = 1'b0; sub = (idx == 2);
      #1;
      if (in_valid && in_ready) idx++;
      if (out_valid) begin
        if (nout < 4) begin
          check($sformatf("bp_out%0d_sum", nout), {16'd0, sum}, {16'd0, bp_e[nout][15:0]});
          check($sformatf("bp_out%0d_cout", nout), {31'd0, cout}, {31'd0, bp_e[nout][16]});
        end else begin
          check("bp_extra_output", nout, 3);
        end
        if (first_cyc < 0) first_cyc = c;
        last_cyc = c;
        nout++;
      end
      tick();
    end
    in_valid = 1'b0;
    check("bp_all_accepted", idx, 4);
    check("bp_out_count", nout, 4);
    check("bp_back_to_back", last_cyc - first_cyc, 3);

    // Reset with two beats in flight.
    in_valid = 1'b1; a = 16'h1111; b = 16'h2222; sub = 1'b0; cin = 1'b1;
    tick();
    a = 16'h3333; b = 16'h4444;
    tick();
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_sum", {16'd0, sum}, 32'd0);
    check("midrst_cout", {31'd0, cout}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("midrst_no_stale", {31'd0, out_valid}, 32'd0);
    end

    // Random traffic against a scoreboard.
    nacc = 0; cyc = 0; held = 1'b0; held_sum = '0;
    while (nacc < 1000 && cyc < 20000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = 16'($urandom);
      b         = 16'($urandom);
      cin       = 1'($urandom);
      sub       = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (held) begin
        check("rnd_hold_valid", {31'd0, out_valid}, 32'd1);
        check("rnd_hold_sum", {16'd0, sum}, {16'd0, held_sum});
      end
      held = out_valid && !out_ready;
      held_sum = sum;
      if (in_valid && in_ready) begin
        expq.push_back(model(a, b, cin, sub));
        nacc++;
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          check("rnd_unexpected_output", 1, 0);
        end else begin
          e = expq.pop_front();
          check("rnd_sum", {16'd0, sum}, {16'd0, e[15:0]});
          check("rnd_cout", {31'd0, cout}, {31'd0, e[16]});
`ifdef CLA_ADDER_OVF_EN
          check("rnd_ovf", {31'd0, ovf}, {31'd0, e[17]});
`endif
        end
      end
      tick();
      cyc++;
    end
    check("rnd_budget", nacc, 1000);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (out_valid) begin
        if (expq.size() == 0) begin
          check("rnd_unexpected_output", 1, 0);
        end else begin
          e = expq.pop_front();
          check("rnd_sum", {16'd0, sum}, {16'd0, e[15:0]});
          check("rnd_cout", {31'd0, cout}, {31'd0, e[16]});
        end
      end
      tick();
    end
    check("rnd_drained", expq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
